membus_arbiter: RTL and testbench

- Two-port arbiter that shares one membus instance between two requesters, for example the CPU and a DMA/loader engine.
- Masters issue single-word read or write transactions.
- The arbiter selects one master per cycle using round-robin, drives the membus address, write data and write strobe for it, and returns an ack plus read data one cycle later.
- Supports pipelined back-to-back operation and a lock for atomic read-modify-write sequences.

---
 rtl/membus_arbiter.sv | 134 +++++++++++++
 tb/tb_membus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Two-port round-robin arbiter sharing one membus. Grant is combinational in
// the issue cycle; ack and read data return one cycle later with a lock for RMW.

module membus_arbiter_port #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant,
  input  logic             we,
  input  logic [width-1:0] bus_data_read,
  output logic             inflight,
  output logic             ack,
  output logic [width-1:0] rdata
);
  logic             pend_we;
  logic [width-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      pend_we  <= 1'b0;
      hold     <= '0;
    end else begin
      inflight <= grant;
      if (grant) pend_we <= we;
      if (inflight && !pend_we) hold <= bus_data_read;
    end
  end

  // Read data passes straight through on the ack cycle, then the hold takes over.
  assign ack   = inflight & ~reset;
  assign rdata = reset ? '0 : ((ack && !pend_we) ? bus_data_read : hold);
endmodule

module membus_arbiter #(
  parameter int width      = 16,
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [addr_width-1:0] r0_addr,
  input  logic [width-1:0]      r0_wdata,
  output logic                  r0_ack,
  output logic [width-1:0]      r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [addr_width-1:0] r1_addr,
  input  logic [width-1:0]      r1_wdata,
  output logic                  r1_ack,
  output logic [width-1:0]      r1_rdata,
  output logic [addr_width-1:0] bus_addr,
  output logic [width-1:0]      bus_data_write,
  output logic                  bus_w_strobe,
  input  logic [width-1:0]      bus_data_read
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]                 req, we, lk, elig, gnt, inflight, ack;
  logic [NUM_PORTS-1:0][addr_width-1:0] addr;
  logic [NUM_PORTS-1:0][width-1:0]      wdata, rdata;
  logic                                 last_gnt, lock_held, lock_owner;
  logic                                 sel, gnt_any;
  logic [addr_width-1:0]                addr_q;
  logic [width-1:0]                     wdata_q;

  assign req   = {r1_req, r0_req};
  assign we    = {r1_we, r0_we};
  assign lk    = {r1_lock, r0_lock};
  assign addr  = {r1_addr, r0_addr};
  assign wdata = {r1_wdata, r0_wdata};

  // A port with an ack due this cycle is skipped so its held req is not re-granted.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : gen_elig
    assign elig[i] = ~reset & req[i] & ~inflight[i] & ~(lock_held & (lock_owner != 1'(i)));
  end

  always_comb begin
    gnt_any = |elig;
    sel     = (&elig) ? ~last_gnt : elig[1];
    gnt     = '0;
    if (gnt_any) gnt = sel ? 2'b10 : 2'b01;
  end

  assign bus_addr       = gnt_any ? addr[sel]  : addr_q;
  assign bus_data_write = gnt_any ? wdata[sel] : wdata_q;
  assign bus_w_strobe   = gnt_any & we[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= 1'b1;  // port 0 wins the first tie
      lock_held  <= 1'b0;
      lock_owner <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (gnt_any) begin
      last_gnt <= sel;
      addr_q   <= addr[sel];
      wdata_q  <= wdata[sel];
      if (lk[sel]) begin
        lock_held  <= 1'b1;
        lock_owner <= sel;
      end else if (lock_held && lock_owner == sel) begin
        lock_held <= 1'b0;
      end
    end
  end

  membus_arbiter_port #(.width(width)) u_port [NUM_PORTS-1:0] (
    .clk           (clk),
    .reset         (reset),
    .grant         (gnt),
    .we            (we),
    .bus_data_read (bus_data_read),
    .inflight      (inflight),
    .ack           (ack),
    .rdata         (rdata)
  );

  assign r0_ack   = ack[0];
  assign r1_ack   = ack[1];
  assign r0_rdata = rdata[0];
  assign r1_rdata = rdata[1];

  // A pending request that was neither granted nor acked must still be there next cycle.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : gen_chk
    a_req_held: assert property (@(posedge clk) disable iff (reset)
      (req[i] && !gnt[i] && !inflight[i]) |=> req[i]);
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// Randomized + directed bench for membus_arbiter: per-port expected-response
// queues filled at issue, drained by a monitor on every ack.
module tb_membus_arbiter;
  localparam int W = 16, AW = 9;

  logic          clk = 0, reset = 1;
  logic          r0_req = 0, r0_we = 0, r0_lock = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [W-1:0]  r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r1_ack, bus_w_strobe;
  logic [W-1:0]  r0_rdata, r1_rdata, bus_data_write;
  logic [AW-1:0] bus_addr;
  logic [W-1:0]  bus_data_read = '0;

  always #5 clk = ~clk;

  membus_arbiter #(.width(W), .addr_width(AW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .bus_addr(bus_addr), .bus_data_write(bus_data_write), .bus_w_strobe(bus_w_strobe),
    .bus_data_read(bus_data_read));

  // membus: registered read of the issued address
  logic [W-1:0] mem [512];
  logic [W-1:0] model_mem [512];
  always @(posedge clk) begin
    if (bus_w_strobe) mem[bus_addr] <= bus_data_write;
    bus_data_read <= mem[bus_addr];
  end

  typedef struct packed { logic we; logic [W-1:0] rdata; } exp_t;
  exp_t          q0[$], q1[$];
  int            ack0[$], ack1[$], stbc[$];
  logic [AW-1:0] stba[$];
  logic [W-1:0]  stbd[$];
  int            tests = 0, fails = 0, cyc = 0, wr_total = 0, stb_total = 0;
  logic [W-1:0]  shown [2];
  logic [1:0]    prev_ack = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_port(input int p, input logic a, input logic [W-1:0] rd);
    exp_t e;
    int   n;
    if (a) begin
      check($sformatf("b2b_ack_p%0d", p), prev_ack[p], 0);
      if (p == 0) ack0.push_back(cyc); else ack1.push_back(cyc);
      n = (p == 0) ? q0.size() : q1.size();
      if (n == 0) check($sformatf("spurious_ack_p%0d", p), a, 0);
      else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        if (!e.we) shown[p] = e.rdata;
        check($sformatf("rdata_ack_p%0d", p), rd, shown[p]);
      end
    end else check($sformatf("rdata_hold_p%0d", p), rd, shown[p]);
    prev_ack[p] = a;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("ack_in_reset", {r1_ack, r0_ack}, 0);
      check("strobe_in_reset", bus_w_strobe, 0);
      shown[0] = '0; shown[1] = '0; prev_ack = '0;
    end else begin
      if (bus_w_strobe) begin
        stb_total++;
        stbc.push_back(cyc); stba.push_back(bus_addr); stbd.push_back(bus_data_write);
      end
      mon_port(0, r0_ack, r0_rdata);
      mon_port(1, r1_ack, r1_rdata);
    end
  end

  task automatic drive(input int p, input bit rq, input bit we, input bit lk,
                       input logic [AW-1:0] a, input logic [W-1:0] wd);
    if (p == 0) begin r0_req = rq; r0_we = we; r0_lock = lk; r0_addr = a; r0_wdata = wd; end
    else        begin r1_req = rq; r1_we = we; r1_lock = lk; r1_addr = a; r1_wdata = wd; end
  endtask

  // Present one transaction from the next cycle on and block until its ack.
  task automatic txn(input int p, input bit we, input bit lk,
                     input logic [AW-1:0] a, input logic [W-1:0] wd);
    exp_t e;
    bit   got = 0;
    @(posedge clk); #1;
    drive(p, 1, we, lk, a, wd);
    e.we = we;
    if (we) begin model_mem[a] = wd; e.rdata = '0; wr_total++; end
    else e.rdata = model_mem[a];
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    for (int n = 0; n < 80 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? r0_ack : r1_ack;
    end
    check($sformatf("ack_timeout_p%0d", p), got, 1);
  endtask

  task automatic idle(input int p);
    @(posedge clk); #1;
    drive(p, 0, 0, 0, '0, '0);
  endtask

  task automatic clear_logs();
    ack0.delete(); ack1.delete(); stbc.delete(); stba.delete(); stbd.delete();
  endtask

  task automatic rand_port(input int p);
    logic [AW-1:0] a;
    bit            we, lk;
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1));
      lk = (k < 149) && ($urandom_range(0, 3) == 0);
      a  = 9'($urandom_range(0, 255));
      a[8] = (p == 1);
      txn(p, we, lk, a, 16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        idle(p);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    idle(p);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < 512; i++) begin mem[i] = 16'($urandom); model_mem[i] = mem[i]; end
    mem[9'h010] = 16'h1111; model_mem[9'h010] = 16'h1111;
    mem[9'h020] = 16'h2222; model_mem[9'h020] = 16'h2222;
    mem[9'h040] = 16'h4040; model_mem[9'h040] = 16'h4040;

    // reset with a write request pending: no strobe may appear
    drive(1, 1, 1, 0, 9'h1FF, 16'hDEAD);
    repeat (2) begin @(negedge clk); check("rst_strobe", bus_w_strobe, 0); end
    drive(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_r0_ack", r0_ack, 0);   check("rst_r1_ack", r1_ack, 0);
    check("rst_r0_rdata", r0_rdata, 0); check("rst_r1_rdata", r1_rdata, 0);
    check("rst_strobe_idle", bus_w_strobe, 0);

    // both ports continuously reading: strict alternation starting with r0
    clear_logs(); s = cyc + 1;
    fork
      begin for (int k = 0; k < 4; k++) txn(0, 0, 0, 9'h010, '0); idle(0); end
      begin for (int k = 0; k < 4; k++) txn(1, 0, 0, 9'h020, '0); idle(1); end
    join
    check("alt_count0", ack0.size(), 4); check("alt_count1", ack1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("alt_ack0_cyc", (k < ack0.size()) ? ack0[k] : -1, s + 1 + 2*k);
      check("alt_ack1_cyc", (k < ack1.size()) ? ack1[k] : -1, s + 2 + 2*k);
    end

    // port 0 write then read back
    clear_logs();
    txn(0, 1, 0, 9'h012, 16'hBEEF);
    txn(0, 0, 0, 9'h012, '0);
    idle(0);
    @(negedge clk);
    check("wr_stb_count", stbc.size(), 1);
    if (stbc.size() > 0 && ack0.size() > 0) begin
      check("wr_stb_cyc", stbc[0], ack0[0] - 1);
      check("wr_stb_addr", stba[0], 9'h012);
      check("wr_stb_data", stbd[0], 16'hBEEF);
    end
    check("rd_back_hold", r0_rdata, 16'hBEEF);

    // port 1 write into the GPIO window
    clear_logs();
    txn(1, 1, 0, 9'h100, 16'h00A5);
    idle(1);
    check("gpio_stb_count", stbc.size(), 1);
    if (stbc.size() > 0 && ack1.size() > 0) begin
      check("gpio_stb_addr", stba[0], 9'h100);
      check("gpio_stb_data", stbd[0], 16'h00A5);
      check("gpio_stb_cyc", stbc[0], ack1[0] - 1);
    end

    // lock: r1 held off until r0's releasing write is granted
    clear_logs();
    fork
      begin
        txn(0, 0, 1, 9'h030, '0);
        idle(0);
        repeat (3) @(posedge clk);
        txn(0, 1, 0, 9'h030, 16'h5A5A);
        idle(0);
      end
      begin @(posedge clk); txn(1, 1, 0, 9'h1C0, 16'h1234); idle(1); end
    join
    check("lock_ack_counts", {ack0.size(), ack1.size()}, {32'd2, 32'd1});
    if (ack0.size() == 2 && ack1.size() == 1) check("lock_r1_after_release", ack1[0], ack0[1] + 1);

    // single port back-to-back reads
    clear_logs(); s = cyc + 1;
    for (int k = 0; k < 4; k++) txn(0, 0, 0, 9'(9'h060 + k), '0);
    idle(0);
    for (int k = 0; k < 4; k++) check("b2b_ack_cyc", (k < ack0.size()) ? ack0[k] : -1, s + 1 + 2*k);

    // reset in the response cycle of a locked r0 read
    txn(0, 0, 1, 9'h040, '0);
    @(posedge clk); #1 drive(0, 1, 0, 1, 9'h041, '0);
    @(posedge clk); #1 begin reset = 1; drive(0, 0, 0, 0, '0, '0); end
    @(negedge clk); check("rstmid_ack", r0_ack, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rstmid_ack_after", r0_ack, 0);
    check("rstmid_rdata0", r0_rdata, 0);
    check("rstmid_rdata1", r1_rdata, 0);
    clear_logs(); s = cyc + 1;
    fork
      begin txn(0, 0, 0, 9'h050, '0); idle(0); end
      begin txn(1, 0, 0, 9'h150, '0); idle(1); end
    join
    check("rstmid_counts", {ack0.size(), ack1.size()}, {32'd1, 32'd1});
    if (ack0.size() == 1 && ack1.size() == 1) begin
      check("rstmid_r0_first", ack0[0], s + 1);
      check("rstmid_r1_next", ack1[0], s + 2);
    end

    // randomized traffic on disjoint address halves
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("strobe_vs_writes", stb_total, wr_total);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
